// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS32 control path: FSM states, opcodes and
// the select/operation codes seen by the ALU control and the datapath muxes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_R_EXEC,
        S_R_WB,
        S_I_EXEC,
        S_I_WB,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_REG     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Next state after DECODE; unrecognised opcodes go to TRAP.
    function automatic state_t decode_next(input logic [5:0] op);
        state_t nxt;
        case (op)
            OP_RTYPE:     nxt = S_R_EXEC;
            OP_LW, OP_SW: nxt = S_MEM_ADDR;
            OP_ADDI:      nxt = S_I_EXEC;
            OP_BEQ:       nxt = S_BRANCH;
            OP_J:         nxt = S_JUMP;
            default:      nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_retire_cnt.sv
// Retired-instruction counter: wraps modulo 2^CNT_W, cleared asynchronously by reset.
module mc_retire_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control unit sequencing the multicycle MIPS32 datapath; only the memory-handshake
// enables look at mem_ready combinationally, everything else decodes the state register.
module multicycle_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    input  logic             ZF,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic [1:0]       PCSrc,
    output logic             IorD,
    output logic             MemToRead,
    output logic             MemToWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       AluOp,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    state_t state_reg;

    // ZF qualifies PCWriteCond inside the datapath, so the sequencer never needs it.
    logic unused_zf;
    assign unused_zf = ZF;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:     state_reg <= S_FETCH;
                S_FETCH:    if (mem_ready) state_reg <= S_DECODE;
                S_DECODE:   state_reg <= decode_next(OpCode);
                S_MEM_ADDR: state_reg <= (OpCode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   if (mem_ready) state_reg <= S_MEM_WB;
                S_MEM_WR:   if (mem_ready) state_reg <= S_FETCH;
                S_R_EXEC:   state_reg <= S_R_WB;
                S_I_EXEC:   state_reg <= S_I_WB;
                S_MEM_WB,
                S_R_WB,
                S_I_WB,
                S_BRANCH,
                S_JUMP:     state_reg <= S_FETCH;
                S_TRAP:     state_reg <= S_TRAP;
                default:    state_reg <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSrc       = PCSRC_ALU;
        IorD        = 1'b0;
        MemToRead   = 1'b0;
        MemToWrite  = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        MemToReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = ALUSRCB_REG;
        AluOp       = ALUOP_ADD;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (state_reg)
            S_FETCH: begin
                MemToRead = 1'b1;
                ALUSrcB   = ALUSRCB_FOUR;
                PCSrc     = PCSRC_ALU;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = ALUSRCB_IMM_SH2;
            end
            S_MEM_ADDR, S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ALUSRCB_IMM;
            end
            S_MEM_RD: begin
                MemToRead = 1'b1;
                IorD      = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemToReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                // Strobe stays up through the stall; the store retires on the ready cycle.
                MemToWrite = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ALUSRCB_REG;
                AluOp   = ALUOP_FUNCT;
            end
            S_R_WB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_I_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = ALUSRCB_REG;
                AluOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSrc       = PCSRC_ALUOUT;
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSrc      = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            S_TRAP: begin
                illegal_op = 1'b1;
            end
            default: begin
            end
        endcase
    end

    mc_retire_cnt #(
        .CNT_W(CNT_W)
    ) u_retire_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (instr_done),
        .count (retired)
    );

endmodule
